// File: rtl/pontos_pkg.sv
// Shared constants and types for the pontos_flutuantes custom-format adder.
// Word layout: {sign, exp[5:0], frac[24:0]}, hidden leading 1, exp 0 encodes zero.
package pontos_pkg;

   localparam int EXP_W        = 6;
   localparam int FRAC_W       = 25;
   localparam int BIAS         = 31;
   localparam int MANT_W       = FRAC_W + 1;
   // Datapath: carry, hidden, fraction, guard, round, sticky.
   localparam int DP_W         = FRAC_W + 5;
   localparam int STICKY_LIMIT = 28;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORMALIZE,
      ST_ROUND,
      ST_DONE
   } state_e;

   localparam int STAT_EXACT     = 0;
   localparam int STAT_OVERFLOW  = 1;
   localparam int STAT_UNDERFLOW = 2;
   localparam int STAT_INEXACT   = 3;

   function automatic logic [3:0] status_bit(input int idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right barrel shifter for operand alignment; every bit shifted
// past position 0 is folded into the sticky bit.
module fp_align_shifter
   import pontos_pkg::*;
(
   input  logic [DP_W-1:0]  data_in,
   input  logic [EXP_W-1:0] shamt,
   output logic [DP_W-1:0]  data_out
);

   logic [DP_W-1:0] shifted;
   logic [DP_W-1:0] lost_mask;
   logic            lost;

   always_comb begin
      shifted   = data_in >> shamt;
      lost_mask = (DP_W'(1) << shamt) - DP_W'(1);
      lost      = |(data_in & lost_mask);
      // Far-away operands only matter as a nonzero tail below the round bit.
      if (shamt >= EXP_W'(STICKY_LIMIT)) begin
         data_out = {{(DP_W-1){1'b0}}, |data_in};
      end else begin
         data_out = {shifted[DP_W-1:1], shifted[0] | lost};
      end
   end

endmodule

// File: rtl/pontos_flutuantes.sv
// Multi-cycle adder for the 1/6/25 custom float format: align, add, normalize,
// round-to-nearest-even, then publish the sum with a one-hot status code.
module pontos_flutuantes
   import pontos_pkg::*;
(
   input  logic        clock_100kHz,
   input  logic        reset,
   input  logic [31:0] op_A_in,
   input  logic [31:0] op_B_in,
   output logic [31:0] data_out,
   output logic [3:0]  status_out
);

   state_e            state_q, state_d;
   logic [31:0]       op_a_q, op_a_d;
   logic [31:0]       op_b_q, op_b_d;
   logic              sign_q, sign_d;
   logic              sub_q, sub_d;
   logic [EXP_W:0]    exp_q, exp_d;
   logic [DP_W-1:0]   acc_q, acc_d;
   logic [DP_W-1:0]   addend_q, addend_d;
   logic [31:0]       result_q, result_d;
   logic [3:0]        res_status_q, res_status_d;
   logic [31:0]       data_out_q, data_out_d;
   logic [3:0]        status_out_q, status_out_d;

   logic [EXP_W-1:0]  ea, eb, big_e, small_e, shamt;
   logic [MANT_W-1:0] ma, mb, big_m, small_m;
   logic              a_ge_b, big_s;
   logic [DP_W-1:0]   shift_in, shifted_b, sum;
   logic [EXP_W:0]    exp_inc, exp_dec;
   logic              round_up, inexact;
   logic [MANT_W:0]   rounded;
   logic [31:0]       sat_word;

   // Operand unpacking and magnitude ordering; exponent 0 forces a zero mantissa.
   always_comb begin
      ea      = op_a_q[30:25];
      eb      = op_b_q[30:25];
      ma      = (ea == '0) ? '0 : {1'b1, op_a_q[FRAC_W-1:0]};
      mb      = (eb == '0) ? '0 : {1'b1, op_b_q[FRAC_W-1:0]};
      a_ge_b  = {ea, ma} >= {eb, mb};
      big_e   = a_ge_b ? ea : eb;
      small_e = a_ge_b ? eb : ea;
      big_m   = a_ge_b ? ma : mb;
      small_m = a_ge_b ? mb : ma;
      big_s   = a_ge_b ? op_a_q[31] : op_b_q[31];
      shamt   = big_e - small_e;
      shift_in = {1'b0, small_m, 3'b000};
   end

   fp_align_shifter u_align_shifter (
      .data_in  (shift_in),
      .shamt    (shamt),
      .data_out (shifted_b)
   );

   assign sum      = sub_q ? (acc_q - addend_q) : (acc_q + addend_q);
   assign exp_inc  = exp_q + (EXP_W+1)'(1);
   assign exp_dec  = exp_q - (EXP_W+1)'(1);
   assign inexact  = |acc_q[2:0];
   assign round_up = acc_q[2] & (acc_q[1] | acc_q[0] | acc_q[3]);
   assign rounded  = {1'b0, acc_q[DP_W-2:3]} + (MANT_W+1)'(round_up);
   assign sat_word = {sign_q, EXP_MAX, {FRAC_W{1'b1}}};

   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      sign_d       = sign_q;
      sub_d        = sub_q;
      exp_d        = exp_q;
      acc_d        = acc_q;
      addend_d     = addend_q;
      result_d     = result_q;
      res_status_d = res_status_q;
      data_out_d   = data_out_q;
      status_out_d = status_out_q;
      case (state_q)
         ST_IDLE: begin
            op_a_d  = op_A_in;
            op_b_d  = op_B_in;
            state_d = ST_ALIGN;
         end
         ST_ALIGN: begin
            sign_d   = big_s;
            sub_d    = op_a_q[31] ^ op_b_q[31];
            exp_d    = {1'b0, big_e};
            acc_d    = {1'b0, big_m, 3'b000};
            addend_d = shifted_b;
            state_d  = ST_ADD;
         end
         ST_ADD: begin
            if (sum == '0) begin
               result_d     = '0;
               res_status_d = status_bit(STAT_EXACT);
               state_d      = ST_DONE;
            end else begin
               acc_d   = sum;
               state_d = ST_NORMALIZE;
            end
         end
         ST_NORMALIZE: begin
            if (acc_q[DP_W-1]) begin
               if (exp_inc[EXP_W]) begin
                  result_d     = sat_word;
                  res_status_d = status_bit(STAT_OVERFLOW);
                  state_d      = ST_DONE;
               end else begin
                  acc_d   = {1'b0, acc_q[DP_W-1:2], acc_q[1] | acc_q[0]};
                  exp_d   = exp_inc;
                  state_d = ST_ROUND;
               end
            end else if (!acc_q[DP_W-2]) begin
               // One position per cycle; exponent 1 is the smallest representable.
               if (exp_q <= (EXP_W+1)'(1)) begin
                  result_d     = '0;
                  res_status_d = status_bit(STAT_UNDERFLOW);
                  state_d      = ST_DONE;
               end else begin
                  acc_d = {acc_q[DP_W-2:0], 1'b0};
                  exp_d = exp_dec;
               end
            end else begin
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_d = ST_DONE;
            if (rounded[MANT_W]) begin
               if (exp_inc[EXP_W]) begin
                  result_d     = sat_word;
                  res_status_d = status_bit(STAT_OVERFLOW);
               end else begin
                  result_d     = {sign_q, exp_inc[EXP_W-1:0], rounded[FRAC_W:1]};
                  res_status_d = status_bit(STAT_INEXACT);
               end
            end else begin
               result_d     = {sign_q, exp_q[EXP_W-1:0], rounded[FRAC_W-1:0]};
               res_status_d = inexact ? status_bit(STAT_INEXACT) : status_bit(STAT_EXACT);
            end
         end
         ST_DONE: begin
            data_out_d   = result_q;
            status_out_d = res_status_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         sign_q       <= 1'b0;
         sub_q        <= 1'b0;
         exp_q        <= '0;
         acc_q        <= '0;
         addend_q     <= '0;
         result_q     <= '0;
         res_status_q <= '0;
         data_out_q   <= '0;
         status_out_q <= '0;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         sign_q       <= sign_d;
         sub_q        <= sub_d;
         exp_q        <= exp_d;
         acc_q        <= acc_d;
         addend_q     <= addend_d;
         result_q     <= result_d;
         res_status_q <= res_status_d;
         data_out_q   <= data_out_d;
         status_out_q <= status_out_d;
      end
   end

   assign data_out   = data_out_q;
   assign status_out = status_out_q;

endmodule

// File: tb/tb_pontos_flutuantes.sv
// Bench for pontos_flutuantes: fixed vectors, latency/capture and reset-abort
// sequences, and random operands checked against an exact-arithmetic model.
module tb_pontos_flutuantes;

   localparam int SETTLE = 80;

   logic        clock_100kHz = 1'b0;
   logic        reset;
   logic [31:0] op_A_in;
   logic [31:0] op_B_in;
   logic [31:0] data_out;
   logic [3:0]  status_out;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [35:0] exp_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] data;
      logic [3:0]  status;
   } vec_t;

   vec_t vecs[$];

   // 10 time units stand for one 10 us period of the system clock.
   always #5 clock_100kHz = ~clock_100kHz;

   pontos_flutuantes dut (
      .clock_100kHz (clock_100kHz),
      .reset        (reset),
      .op_A_in      (op_A_in),
      .op_B_in      (op_B_in),
      .data_out     (data_out),
      .status_out   (status_out)
   );

   // Exact sum on wide integers (units of 2^-55), then RNE to a 26-bit mantissa.
   function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      logic [127:0] ma, mb, mag, mant, rem, half;
      logic         s, inx, up;
      int           ea, eb, p, e_res, sh;
      ea = int'(a[30:25]);
      eb = int'(b[30:25]);
      ma = (ea == 0) ? 128'd0 : (128'({1'b1, a[24:0]}) << (ea - 1));
      mb = (eb == 0) ? 128'd0 : (128'({1'b1, b[24:0]}) << (eb - 1));
      if (a[31] == b[31]) begin
         mag = ma + mb;
         s   = a[31];
      end else if (ma >= mb) begin
         mag = ma - mb;
         s   = a[31];
      end else begin
         mag = mb - ma;
         s   = b[31];
      end
      if (mag == 128'd0) return {32'h0, 4'b0001};
      p = 0;
      for (int i = 0; i < 128; i++) if (mag[i]) p = i;
      e_res = p - 24;
      if (e_res < 1) return {32'h0, 4'b0100};
      inx = 1'b0;
      up  = 1'b0;
      if (p >= 25) begin
         sh   = p - 25;
         mant = mag >> sh;
         rem  = mag - (mant << sh);
         if (sh > 0) begin
            half = 128'd1 << (sh - 1);
            inx  = (rem != 128'd0);
            up   = (rem > half) || ((rem == half) && mant[0]);
         end
      end else begin
         mant = mag << (25 - p);
      end
      if (up) mant = mant + 128'd1;
      if (mant[26]) begin
         mant  = mant >> 1;
         e_res = e_res + 1;
      end
      if (e_res > 63) return {s, 6'h3F, 25'h1FFFFFF, 4'b0010};
      return {s, 6'(e_res), mant[24:0], (inx ? 4'b1000 : 4'b0001)};
   endfunction

   function automatic logic [5:0] clamp_exp(input int e);
      if (e < 0) return 6'd0;
      if (e > 63) return 6'd63;
      return 6'(e);
   endfunction

   task automatic step();
      @(posedge clock_100kHz);
      #1;
   endtask

   task automatic check(input string name, input logic [35:0] req);
      n_vec++;
      if ({data_out, status_out} !== req) begin
         n_miss++;
         $display("FAIL %s: data_out=%h status_out=%b, required data_out=%h status_out=%b",
                  name, data_out, status_out, req[35:4], req[3:0]);
      end
   endtask

   // Holds operands long enough for any in-flight operation plus one full new one.
   task automatic run_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [35:0] req);
      op_A_in = a;
      op_B_in = b;
      exp_q.push_back(req);
      repeat (SETTLE) step();
      check(name, exp_q.pop_front());
   endtask

   task automatic wait_result(input string name, input logic [35:0] req, input int budget);
      for (int k = 0; k < budget; k++) begin
         step();
         if ({data_out, status_out} === req) break;
      end
      check(name, req);
   endtask

   task automatic fill_vectors();
      vecs.push_back('{32'h3E000000, 32'h40000000, 32'h41000000, 4'b0001}); // 1 + 2
      vecs.push_back('{32'h3E000000, 32'hBE000000, 32'h00000000, 4'b0001}); // 1 - 1
      vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0010}); // carry overflow
      vecs.push_back('{32'h02000001, 32'h82000000, 32'h00000000, 4'b0100}); // underflow
      vecs.push_back('{32'h3E000000, 32'h02000000, 32'h3E000000, 4'b1000}); // sticky only
      vecs.push_back('{32'h00000000, 32'h80000000, 32'h00000000, 4'b0001}); // 0 + -0
      vecs.push_back('{32'h00000000, 32'hC1000000, 32'hC1000000, 4'b0001}); // 0 + -3
      vecs.push_back('{32'h01FFFFFF, 32'h3E000000, 32'h3E000000, 4'b0001}); // exp 0 ignores frac
      vecs.push_back('{32'h3E000001, 32'hBE000000, 32'h0C000000, 4'b0001}); // 25-step normalize
      vecs.push_back('{32'h3E000000, 32'h0A000000, 32'h3E000000, 4'b1000}); // tie, stay even
      vecs.push_back('{32'h3E000001, 32'h0A000000, 32'h3E000002, 4'b1000}); // tie, round to even
      vecs.push_back('{32'h3FFFFFFF, 32'h0A000000, 32'h40000000, 4'b1000}); // round carry-out
      vecs.push_back('{32'h7FFFFFFF, 32'h4A000000, 32'h7FFFFFFF, 4'b0010}); // round overflow
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010}); // negative overflow
      vecs.push_back('{32'h7E000000, 32'h7E000000, 32'h7FFFFFFF, 4'b0010}); // 2^32 + 2^32
      vecs.push_back('{32'h3E000000, 32'hC0000000, 32'hBE000000, 4'b0001}); // B larger
      vecs.push_back('{32'h3E000000, 32'h82000000, 32'h3E000000, 4'b1000}); // 1 - 2^-30
      vecs.push_back('{32'h04000000, 32'h82000000, 32'h02000000, 4'b0001}); // lands on exp 1
      vecs.push_back('{32'h02000000, 32'h02000000, 32'h04000000, 4'b0001}); // smallest doubled
   endtask

   task automatic gen_random(output logic [31:0] a, output logic [31:0] b);
      int mode, ea;
      a    = $urandom;
      b    = $urandom;
      mode = int'($urandom_range(0, 5));
      ea   = int'(a[30:25]);
      case (mode)
         1: begin
            b[31]    = ~a[31];
            b[30:25] = clamp_exp(ea + int'($urandom_range(0, 2)) - 1);
            b[24:0]  = a[24:0] ^ 25'($urandom_range(0, 15));
         end
         2: b[30:25] = clamp_exp(ea - int'($urandom_range(25, 31)));
         3: begin
            a[30:25] = 6'($urandom_range(60, 63));
            b[30:25] = 6'($urandom_range(58, 63));
         end
         4: begin
            a[30:25] = 6'($urandom_range(1, 3));
            b[30:25] = 6'($urandom_range(1, 3));
         end
         5: b[30:25] = 6'd0;
         default: ;
      endcase
   endtask

   initial begin
      logic [31:0] ra, rb;
      reset   = 1'b1;
      op_A_in = 32'h0;
      op_B_in = 32'h0;
      repeat (2) step();
      check("reset_state", {32'h0, 4'b0000});

      // First result within 6 cycles; operands changed after capture must not leak in.
      op_A_in = 32'h3E000000;
      op_B_in = 32'h40000000;
      reset   = 1'b0;
      step();
      op_A_in = 32'h3E000000;
      op_B_in = 32'h3E000000;
      wait_result("latency_6", {32'h41000000, 4'b0001}, 5);
      wait_result("next_capture", {32'h40000000, 4'b0001}, SETTLE);

      fill_vectors();
      foreach (vecs[i]) begin
         run_vector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, {vecs[i].data, vecs[i].status});
      end

      for (int i = 0; i < 250; i++) begin
         gen_random(ra, rb);
         run_vector($sformatf("rand%0d a=%h b=%h", i, ra, rb), ra, rb, ref_add(ra, rb));
      end

      // Abort during a long left normalization.
      op_A_in = 32'h3E000000;
      op_B_in = 32'h40000000;
      reset   = 1'b1;
      step();
      reset   = 1'b0;
      wait_result("abort_setup", {32'h41000000, 4'b0001}, 20);
      op_A_in = 32'h3E000001;
      op_B_in = 32'hBE000000;
      repeat (5) step();
      reset = 1'b1;
      #1;
      check("abort_async_clear", {32'h0, 4'b0000});
      step();
      check("abort_hold", {32'h0, 4'b0000});
      reset = 1'b0;
      repeat (SETTLE) step();
      check("abort_resume", {32'h0C000000, 4'b0001});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
